// File: rtl/cog_pkg.sv
// Shared cog definitions: capture mode encodings, capture FSM states and the
// bit positions of the cap/scl configuration fields.
package cog_pkg;

    typedef enum logic [1:0] {
        CAP_OFF  = 2'b00,
        CAP_FREE = 2'b01,
        CAP_RISE = 2'b10,
        CAP_FALL = 2'b11
    } cap_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } cap_state_e;

    localparam int CAP_MODE_HI = 30;
    localparam int CAP_MODE_LO = 29;
    localparam int CAP_TWO_BIT = 28;
    localparam int CAP_IDX_HI  = 18;
    localparam int CAP_IDX_LO  = 16;
    localparam int CAP_TIDX_HI = 15;
    localparam int CAP_TIDX_LO = 13;
    localparam int CAP_GRP_HI  = 10;
    localparam int CAP_GRP_LO  = 9;
    localparam int CAP_MASK_HI = 7;
    localparam int CAP_MASK_LO = 0;

    localparam int SCL_CPP_HI  = 19;
    localparam int SCL_CPP_LO  = 12;
    localparam int SCL_PPW_HI  = 5;
    localparam int SCL_PPW_LO  = 0;

    // Out-of-range pixel counts fall back to a full word; 2-bit pixels fill a word at 16.
    function automatic logic [5:0] pixelsPerWord(input logic [5:0] raw, input logic twoBit);
        logic [5:0] n;
        n = (raw == 6'd0 || raw > 6'd32) ? 6'd32 : raw;
        if (twoBit && n > 6'd16) begin
            n = 6'd16;
        end
        return n;
    endfunction

    function automatic logic [7:0] selectGroup(input logic [31:0] pins, input logic [1:0] grp,
                                               input logic [7:0] mask);
        return pins[{grp, 3'b000} +: 8] & mask;
    endfunction

endpackage

// File: rtl/cog_vcap_sync.sv
// Multi-stage synchroniser bringing the asynchronous 32-bit pin bus into the cog clock domain.
module cog_vcap_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_cog,
    input  logic        res,
    input  logic [31:0] i_async,
    output logic [31:0] o_sync
);

    logic [SYNC_STAGES-1:0][31:0] r_stage;

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/cog_vcap.sv
// Cog video capture: samples one pin (or pin pair) of an 8-pin group at a programmable
// pixel rate and packs the pixels into 32-bit words handed to the cog via rdy/take.
module cog_vcap
    import cog_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_cog,
    input  logic        res,
    input  logic        setcap,
    input  logic        setscl,
    input  logic [31:0] data,
    input  logic [31:0] pin_in,
    input  logic        take,
    output logic [31:0] word,
    output logic        rdy,
    output logic        armed,
    output logic        overrun
);

    logic [31:0] w_pins;

    cap_state_e  r_state;
    logic        r_falling;
    logic        r_twoBit;
    logic [2:0]  r_idx;
    logic [2:0]  r_tidx;
    logic [1:0]  r_grpSel;
    logic [7:0]  r_mask;
    logic [7:0]  r_cpp;
    logic [5:0]  r_ppw;
    logic [31:0] r_sr;
    logic [31:0] r_word;
    logic [7:0]  r_presc;
    logic [5:0]  r_cnt;
    logic [5:0]  r_nCur;
    logic        r_rdy;
    logic        r_armed;
    logic        r_overrun;
    logic        r_prevTrig;

    logic [7:0]  w_grp;
    logic [7:0]  w_grpNew;
    logic        w_trig;
    logic        w_trigNew;
    logic        w_trigHit;
    logic [1:0]  w_px;
    logic [31:0] w_srNext;
    logic [31:0] w_wordNext;
    logic        w_sample;
    logic        w_done;
    logic [5:0]  w_cntNext;
    logic [5:0]  w_bits;
    logic [5:0]  w_shift;
    logic        w_unusedData;

    cog_vcap_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_cog (clk_cog),
        .res     (res),
        .i_async (pin_in),
        .o_sync  (w_pins)
    );

    // The trigger level seen under the incoming config seeds edge detection on entry to ARM.
    assign w_grp      = selectGroup(w_pins, r_grpSel, r_mask);
    assign w_grpNew   = selectGroup(w_pins, data[CAP_GRP_HI:CAP_GRP_LO], data[CAP_MASK_HI:CAP_MASK_LO]);
    assign w_trig     = w_grp[r_tidx];
    assign w_trigNew  = w_grpNew[data[CAP_TIDX_HI:CAP_TIDX_LO]];
    assign w_trigHit  = (w_trig != r_prevTrig) && (w_trig != r_falling);

    assign w_px       = r_twoBit ? {w_grp[{r_idx[2:1], 1'b1}], w_grp[{r_idx[2:1], 1'b0}]}
                                 : {1'b0, w_grp[r_idx]};
    assign w_srNext   = r_twoBit ? {w_px, r_sr[31:2]} : {w_px[0], r_sr[31:1]};
    assign w_sample   = !setcap && (r_state == ST_RUN) && (r_presc == 8'd1);
    assign w_cntNext  = r_cnt + 6'd1;
    assign w_done     = w_sample && (w_cntNext == r_nCur);
    assign w_bits     = r_twoBit ? {r_nCur[4:0], 1'b0} : r_nCur;
    assign w_shift    = 6'd32 - w_bits;
    assign w_wordNext = w_srNext >> w_shift;

    assign w_unusedData = ^{data[31], data[27:20], data[11], data[8]};

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            r_state    <= ST_IDLE;
            r_falling  <= 1'b0;
            r_twoBit   <= 1'b0;
            r_idx      <= '0;
            r_tidx     <= '0;
            r_grpSel   <= '0;
            r_mask     <= '0;
            r_cpp      <= '0;
            r_ppw      <= '0;
            r_sr       <= '0;
            r_word     <= '0;
            r_presc    <= '0;
            r_cnt      <= '0;
            r_nCur     <= '0;
            r_rdy      <= 1'b0;
            r_armed    <= 1'b0;
            r_overrun  <= 1'b0;
            r_prevTrig <= 1'b0;
        end else begin
            if (setscl) begin
                r_cpp <= data[SCL_CPP_HI:SCL_CPP_LO];
                r_ppw <= data[SCL_PPW_HI:SCL_PPW_LO];
            end

            if (setcap) begin
                r_falling  <= data[CAP_MODE_LO];
                r_twoBit   <= data[CAP_TWO_BIT];
                r_idx      <= data[CAP_IDX_HI:CAP_IDX_LO];
                r_tidx     <= data[CAP_TIDX_HI:CAP_TIDX_LO];
                r_grpSel   <= data[CAP_GRP_HI:CAP_GRP_LO];
                r_mask     <= data[CAP_MASK_HI:CAP_MASK_LO];
                r_sr       <= '0;
                r_cnt      <= '0;
                r_overrun  <= 1'b0;
                r_prevTrig <= w_trigNew;
                r_presc    <= r_cpp;
                r_nCur     <= pixelsPerWord(r_ppw, data[CAP_TWO_BIT]);
                case (cap_mode_e'(data[CAP_MODE_HI:CAP_MODE_LO]))
                    CAP_OFF: begin
                        r_state <= ST_IDLE;
                        r_armed <= 1'b0;
                    end
                    CAP_FREE: begin
                        r_state <= ST_RUN;
                        r_armed <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_ARM;
                        r_armed <= 1'b1;
                    end
                endcase
            end else begin
                case (r_state)
                    ST_ARM: begin
                        r_prevTrig <= w_trig;
                        if (w_trigHit) begin
                            r_state <= ST_RUN;
                            r_armed <= 1'b0;
                            r_presc <= r_cpp;
                            r_nCur  <= pixelsPerWord(r_ppw, r_twoBit);
                        end
                    end
                    ST_RUN: begin
                        // A prescaler of 0 wraps to 255 here, giving the 256-clock pixel period.
                        if (r_presc == 8'd1) begin
                            r_sr    <= w_srNext;
                            r_presc <= r_cpp;
                            if (w_done) begin
                                r_cnt  <= '0;
                                r_nCur <= pixelsPerWord(r_ppw, r_twoBit);
                            end else begin
                                r_cnt  <= w_cntNext;
                            end
                        end else begin
                            r_presc <= r_presc - 8'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            if (w_done) begin
                if (!r_rdy || take) begin
                    r_word <= w_wordNext;
                    r_rdy  <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (take && r_rdy) begin
                r_rdy <= 1'b0;
            end
        end
    end

    assign word    = r_word;
    assign rdy     = r_rdy;
    assign armed   = r_armed;
    assign overrun = r_overrun;

endmodule

// File: doc/cog_vcap.md
# cog_vcap

Per-cog video capture block: the receive-side counterpart of the cog video generator. It samples a selected pin of an 8-pin group at a programmable pixel rate and packs 1- or 2-bit pixels into 32-bit words. Completed words are handed to the cog through a ready/take handshake. Capture can be free-running or armed on a pin edge. It sits beside the cog, fed from the synchronised pin bus and written by the same configuration instructions as the video generator.

## Interface
Parameters:
- SYNC_STAGES, 2, input synchroniser depth on pin_in (≥2)

Ports:
- clk_cog  input  1  cog clock; the only clock in the block
- res  input  1  asynchronous, active-high reset
- setcap  input  1  one-cycle strobe: load capture config from data
- setscl  input  1  one-cycle strobe: load timing config from data
- data  input  32  configuration write data
- pin_in  input  32  raw pin inputs (asynchronous)
- take  input  1  cog consumes held word (one-cycle strobe)
- word  output  32  captured word (valid while rdy)
- rdy  output  1  held word valid
- armed  output  1  high while waiting for trigger
- overrun  output  1  sticky: word completed while rdy=1 and not taken

## Operation
- cap register (setcap), written from data:
  - [30:29] mode: 00 off, 01 free-run, 10 trigger on rising edge, 11 trigger on falling edge.
  - [28] 2-bit pixels.
  - [18:16] sample bit index.
  - [15:13] trigger bit index.
  - [10:9] group (pins 8g+7..8g).
  - [7:0] mask.
- scl register (setscl), written from data:
  - [19:12] clocks per pixel; 0 = 256.
  - [5:0] pixels per word, 1..32; 0 or >32 = 32. In 2-bit mode the count is clamped to 16.
- grp = sync(pin_in)[8g+7:8g] & mask. The 1-bit pixel is grp[idx]. The 2-bit pixel is grp[{idx[2:1],1}:{idx[2:1],0}], so idx[0] is ignored. The trigger bit is grp[tidx]; a masked-off pin reads 0.
- FSM IDLE/ARM/RUN:
  - Any setcap write clears the shift register, pixel count and overrun.
  - A setcap write then enters IDLE if mode=00, RUN if mode=01, or ARM otherwise.
  - ARM → RUN on the first clock where prev_trig≠trig and trig matches the polarity. prev_trig is initialised from the current trigger bit on entering ARM, so a level already present does not trigger.
  - RUN stays in RUN until the next setcap. There is no re-arm per word.
- Prescaler:
  - Loaded with scl[19:12] on entry to RUN.
  - Decrements each clock; on value 1 it takes a sample and reloads.
  - A value of 0 behaves as 256.
- Shift register sr[31:0] shifts right with the new pixel entering the MSB(s): {px, sr[31:1]} or {px, sr[31:2]}.
- Word completion:
  - On the sample that makes count = n, word ← the new sr value >> (32 − n·bpp), which is right-justified with the oldest pixel at bit 0.
  - The count then resets and the shift register continues.
- Handshake:
  - Completion sets rdy.
  - take while rdy clears rdy.
  - Completion and take in the same cycle: the new word loads and rdy stays 1.
  - Completion while rdy=1 with no take: overrun ← 1, and the held word is retained (the newer word is dropped).
  - take while rdy=0 is ignored.
- setscl during RUN takes effect at the next prescaler reload or the next word boundary. It does not disturb the word in progress.

## Timing
- Reset values: word=0, rdy=0, armed=0, overrun=0, FSM=IDLE, cap=0, scl=0.
- Pin-to-sample latency is SYNC_STAGES clocks.
- rdy rises the clock after the completing sample. word is stable from that edge.
- armed is asserted the clock after a setcap with mode 1x. It drops on the same edge the FSM enters RUN.
- In RUN, the first sample occurs P clocks after RUN entry (P = clocks per pixel). A word completes every n·P clocks.
- Reset asserted mid-capture: all state clears immediately (asynchronously). Capture does not resume until a new setcap.

## Structure
- Shared package (cog_pkg): capture mode encodings, FSM state enum, and the cap/scl field bit positions, shared with the driver and the video generator where fields coincide ([28], [10:9], [7:0]).
- One sub-module, cog_vcap_sync: a SYNC_STAGES-deep 32-bit synchroniser on pin_in.

## Test plan
- Free-run, 1-bit, idx=0, group 0, mask=FF, P=2, n=8, pin 0 driven 1,0,1,1,0,0,1,0 per pixel -> rdy after 16 clocks of RUN plus sync latency; word=0x0000004D.
- 2-bit, idx=2, P=1, n=16, pins[3:2] cycling 0,1,2,3 -> word=0xE4E4E4E4.
- Trigger rising, tidx=5, pin 5 held high at arm then low then high -> no trigger on the initial level; RUN entered on the 0→1 edge; armed drops on the same edge.
- n=4, P=1, take held low -> second completion sets overrun; word keeps the first value; a take coincident with the third completion keeps rdy=1 and loads the third word.
- mask=00 or pin masked off -> all words 0; P=0 -> word period of 256·n clocks.
- res pulsed mid-word -> all outputs 0 immediately; no rdy until after a new setcap.
